mvm_sched: RTL

MVM_SCHED -- requirements
Module: mvm_sched

---
 rtl/mvm_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mvm_sched.sv
// rtl/mvm_sched.sv - sparse activation scheduler: loads a vector, then issues only its nonzero elements in index order
module mvm_sched #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          op_valid,
  output logic [IW-1:0] op_index,
  output logic [W-1:0]  op_value,
  output logic          op_last,
  input  logic          op_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] nnz_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  bitmap;
  logic [W-1:0]  vals [N];
  logic [CW-1:0] nnz_q;

  logic          load_hs;
  logic          op_hs;
  logic          last_load;
  logic [N-1:0]  load_bitmap;
  logic [IW-1:0] low_idx;
  logic          single_left;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] b);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(b[i]);
    end
    return c;
  endfunction

  assign in_ready  = ena && (state == S_LOAD);
  assign op_valid  = ena && (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign done      = ena && (state == S_DONE);
  assign nnz_count = nnz_q;

  assign load_hs   = in_valid && in_ready;
  assign op_hs     = op_valid && op_ready;
  assign last_load = load_hs && (cnt == CW'(N - 1));

  // Bitmap as it will look after this cycle's load, so the LOAD exit sees the final element.
  always_comb begin
    load_bitmap = bitmap;
    if (load_hs) begin
      load_bitmap[cnt[IW-1:0]] = (in_data != '0);
    end
  end

  // Descending scan so the lowest set index wins.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bitmap[i]) begin
        low_idx = IW'(i);
      end
    end
  end

  assign single_left = (bitmap != '0) && ((bitmap & (bitmap - N'(1))) == '0);
  assign op_index    = low_idx;
  assign op_value    = vals[low_idx];
  assign op_last     = (state == S_ISSUE) && single_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitmap <= '0;
      nnz_q  <= '0;
      for (int i = 0; i < N; i++) begin
        vals[i] <= '0;
      end
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            cnt    <= '0;
            bitmap <= '0;
            for (int i = 0; i < N; i++) begin
              vals[i] <= '0;
            end
          end
        end
        S_LOAD: begin
          if (load_hs) begin
            vals[cnt[IW-1:0]] <= in_data;
            bitmap            <= load_bitmap;
            cnt               <= cnt + CW'(1);
            if (last_load) begin
              nnz_q <= popcount(load_bitmap);
              state <= (load_bitmap != '0) ? S_ISSUE : S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (op_hs) begin
            bitmap[low_idx] <= 1'b0;
            if (op_last) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
